// File: rtl/regfile_sequencer.sv
// Command sequencer that owns both ports of the 8-entry register file and expands
// LDI / MOV / SWAP / READ commands into fixed read-then-write cycle sequences.
module regfile_sequencer #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [AW-1:0] req_ra,
   input  logic [AW-1:0] req_rb,
   input  logic [DW-1:0] req_imm,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   input  logic          rsp_ready,
   output logic          op_done,
   output logic [AW-1:0] rf_readnum,
   input  logic [DW-1:0] rf_data_out,
   output logic [AW-1:0] rf_writenum,
   output logic          rf_write,
   output logic [DW-1:0] rf_data_in
);

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      WR_A,
      WR_B,
      RESP
   } state_t;

   localparam logic [1:0] OP_LDI  = 2'b00;
   localparam logic [1:0] OP_MOV  = 2'b01;
   localparam logic [1:0] OP_SWAP = 2'b10;

   state_t          r_state;
   state_t          w_nextState;
   logic [1:0]      r_op;
   logic [AW-1:0]   r_ra;
   logic [AW-1:0]   r_rb;
   logic [DW-1:0]   r_imm;
   logic [DW-1:0]   r_tmpA;
   logic [DW-1:0]   r_tmpB;
   logic            r_opDone;
   logic            w_accept;
   logic            w_opDoneNext;

   assign op_done = r_opDone;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_op     <= '0;
         r_ra     <= '0;
         r_rb     <= '0;
         r_imm    <= '0;
         r_tmpA   <= '0;
         r_tmpB   <= '0;
         r_opDone <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_opDone <= w_opDoneNext;
         if (w_accept) begin
            r_op  <= req_op;
            r_ra  <= req_ra;
            r_rb  <= req_rb;
            r_imm <= req_imm;
         end
         if (r_state == RD_A) begin
            r_tmpA <= rf_data_out;
         end
         if (r_state == RD_B) begin
            r_tmpB <= rf_data_out;
         end
      end
   end

   // Register-file strobes are decoded purely from state so an async reset kills them at once.
   always_comb begin
      w_nextState  = r_state;
      w_accept     = 1'b0;
      w_opDoneNext = 1'b0;
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      rsp_data     = '0;
      rf_readnum   = '0;
      rf_writenum  = '0;
      rf_write     = 1'b0;
      rf_data_in   = '0;
      case (r_state)
         IDLE: begin
            req_ready = reset_n;
            w_accept  = req_valid;
            if (req_valid) begin
               w_nextState = (req_op == OP_LDI) ? WR_A : RD_A;
            end
         end
         RD_A: begin
            rf_readnum = (r_op == OP_MOV) ? r_rb : r_ra;
            if (r_op == OP_MOV) begin
               w_nextState = WR_A;
            end else if (r_op == OP_SWAP) begin
               w_nextState = RD_B;
            end else begin
               w_nextState = RESP;
            end
         end
         RD_B: begin
            rf_readnum  = r_rb;
            w_nextState = WR_A;
         end
         WR_A: begin
            rf_write    = 1'b1;
            rf_writenum = r_ra;
            case (r_op)
               OP_LDI:  rf_data_in = r_imm;
               OP_MOV:  rf_data_in = r_tmpA;
               default: rf_data_in = r_tmpB;
            endcase
            if (r_op == OP_SWAP) begin
               w_nextState = WR_B;
            end else begin
               w_nextState  = IDLE;
               w_opDoneNext = 1'b1;
            end
         end
         WR_B: begin
            rf_write     = 1'b1;
            rf_writenum  = r_rb;
            rf_data_in   = r_tmpA;
            w_nextState  = IDLE;
            w_opDoneNext = 1'b1;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_data  = r_tmpA;
            if (rsp_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file plus an array-level model of
// what each command should do to the registers, driven by a vector table and random commands.
module tb_regfile_sequencer;

   localparam logic [1:0] OP_LDI  = 2'b00;
   localparam logic [1:0] OP_MOV  = 2'b01;
   localparam logic [1:0] OP_SWAP = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

   typedef logic [18:0] wr_t;

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [15:0] imm;
      logic [15:0] expData;
      int          expLat;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetN;
   logic        reqValid;
   logic        reqReady;
   logic [1:0]  reqOp;
   logic [2:0]  reqRa;
   logic [2:0]  reqRb;
   logic [15:0] reqImm;
   logic        rspValid;
   logic [15:0] rspData;
   logic        rspReady;
   logic        opDone;
   logic [2:0]  rfReadnum;
   logic [15:0] rfDataOut;
   logic [2:0]  rfWritenum;
   logic        rfWrite;
   logic [15:0] rfDataIn;

   logic [15:0] rf [8];
   logic [15:0] model [8];
   wr_t         wrLog [$];
   int          tests = 0;
   int          fails = 0;

   regfile_sequencer #(.DW(16), .AW(3)) dut (
      .clk         (clk),
      .reset_n     (resetN),
      .req_valid   (reqValid),
      .req_ready   (reqReady),
      .req_op      (reqOp),
      .req_ra      (reqRa),
      .req_rb      (reqRb),
      .req_imm     (reqImm),
      .rsp_valid   (rspValid),
      .rsp_data    (rspData),
      .rsp_ready   (rspReady),
      .op_done     (opDone),
      .rf_readnum  (rfReadnum),
      .rf_data_out (rfDataOut),
      .rf_writenum (rfWritenum),
      .rf_write    (rfWrite),
      .rf_data_in  (rfDataIn)
   );

   always #5 clk = ~clk;

   // Register file survives reset; every write is also logged for checking.
   assign rfDataOut = rf[rfReadnum];
   always @(posedge clk) begin
      if (rfWrite) begin
         rf[rfWritenum] <= rfDataIn;
         wrLog.push_back({rfWritenum, rfDataIn});
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Issues one command in the current cycle, waits for req_ready, then checks against the model.
   task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [2:0] ra,
                                input logic [2:0] rb, input logic [15:0] imm, input bit stall,
                                output logic [15:0] rdata, output int lat);
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  readA;
      logic [2:0]  readB;
      int          earlyDone;
      wr_t         expW [$];
      wrLog.delete();
      checkOutput({tag, " ready"}, 32'(reqReady), 32'd1);
      reqValid = 1'b1;
      reqOp    = op;
      reqRa    = ra;
      reqRb    = rb;
      reqImm   = imm;
      @(posedge clk); #1;
      reqValid = 1'b0;
      reqOp    = 2'($urandom_range(0, 3));
      reqRa    = 3'($urandom_range(0, 7));
      reqRb    = 3'($urandom_range(0, 7));
      reqImm   = 16'($urandom);
      lat = 1; rdata = '0; readA = '0; readB = '0; earlyDone = 0;
      while (!reqReady && lat < 60) begin
         if (lat == 1) readA = rfReadnum;
         if (lat == 2) readB = rfReadnum;
         if (opDone) earlyDone++;
         if (rspValid) rdata = rspData;
         if (stall) rspReady = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      rspReady = 1'b1;
      checkOutput({tag, " completed in time"}, 32'(lat < 60), 32'd1);
      checkOutput({tag, " op_done"}, 32'(opDone), 32'(op != OP_READ));
      checkOutput({tag, " early op_done"}, 32'(earlyDone), 32'd0);
      a = model[ra];
      b = model[rb];
      case (op)
         OP_LDI: begin
            expW.push_back({ra, imm});
            checkOutput({tag, " readnum idle"}, 32'(readA), 32'd0);
            model[ra] = imm;
         end
         OP_MOV: begin
            expW.push_back({ra, b});
            checkOutput({tag, " readnum src"}, 32'(readA), 32'(rb));
            model[ra] = b;
         end
         OP_SWAP: begin
            expW.push_back({ra, b});
            expW.push_back({rb, a});
            checkOutput({tag, " readnum first"}, 32'(readA), 32'(ra));
            checkOutput({tag, " readnum second"}, 32'(readB), 32'(rb));
            model[ra] = b;
            model[rb] = a;
         end
         default: begin
            checkOutput({tag, " readnum src"}, 32'(readA), 32'(ra));
            checkOutput({tag, " rsp_data"}, 32'(rdata), 32'(a));
         end
      endcase
      checkOutput({tag, " write count"}, 32'(wrLog.size()), 32'(expW.size()));
      for (int i = 0; i < expW.size() && i < wrLog.size(); i++) begin
         checkOutput($sformatf("%s write%0d", tag, i), 32'(wrLog[i]), 32'(expW[i]));
      end
      checkOutput({tag, " reg ra"}, 32'(rf[ra]), 32'(model[ra]));
      checkOutput({tag, " reg rb"}, 32'(rf[rb]), 32'(model[rb]));
   endtask

   initial begin
      vec_t        vecs [$];
      logic [15:0] rdata;
      int          lat;

      for (int i = 0; i < 8; i++) begin
         rf[i]    = '0;
         model[i] = '0;
      end
      resetN = 1'b0; reqValid = 1'b0; reqOp = '0; reqRa = '0; reqRb = '0; reqImm = '0;
      rspReady = 1'b1;

      #1;
      checkOutput("reset req_ready", 32'(reqReady), 32'd0);
      checkOutput("reset rf_write", 32'(rfWrite), 32'd0);
      checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("reset op_done", 32'(opDone), 32'd0);
      #21 resetN = 1'b1;
      @(posedge clk); #1;
      checkOutput("post-reset req_ready", 32'(reqReady), 32'd1);

      vecs.push_back('{OP_LDI,  3'd3, 3'd0, 16'h00A5, 16'h0000, 2});
      vecs.push_back('{OP_READ, 3'd3, 3'd0, 16'h0000, 16'h00A5, 3});
      vecs.push_back('{OP_LDI,  3'd1, 3'd0, 16'h1234, 16'h0000, 2});
      vecs.push_back('{OP_LDI,  3'd2, 3'd0, 16'hBEEF, 16'h0000, 2});
      vecs.push_back('{OP_SWAP, 3'd1, 3'd2, 16'h0000, 16'h0000, 5});
      vecs.push_back('{OP_READ, 3'd1, 3'd0, 16'h0000, 16'hBEEF, 3});
      vecs.push_back('{OP_READ, 3'd2, 3'd0, 16'h0000, 16'h1234, 3});
      vecs.push_back('{OP_LDI,  3'd1, 3'd0, 16'h1234, 16'h0000, 2});
      vecs.push_back('{OP_MOV,  3'd5, 3'd1, 16'h0000, 16'h0000, 3});
      vecs.push_back('{OP_READ, 3'd1, 3'd0, 16'h0000, 16'h1234, 3});
      vecs.push_back('{OP_READ, 3'd5, 3'd0, 16'h0000, 16'h1234, 3});
      vecs.push_back('{OP_LDI,  3'd4, 3'd0, 16'h5A5A, 16'h0000, 2});
      vecs.push_back('{OP_SWAP, 3'd4, 3'd4, 16'h0000, 16'h0000, 5});
      vecs.push_back('{OP_READ, 3'd4, 3'd0, 16'h0000, 16'h5A5A, 3});
      vecs.push_back('{OP_LDI,  3'd6, 3'd0, 16'h0F0F, 16'h0000, 2});
      vecs.push_back('{OP_MOV,  3'd6, 3'd6, 16'h0000, 16'h0000, 3});
      vecs.push_back('{OP_READ, 3'd6, 3'd0, 16'h0000, 16'h0F0F, 3});
      vecs.push_back('{OP_LDI,  3'd7, 3'd0, 16'hFFFF, 16'h0000, 2});
      vecs.push_back('{OP_LDI,  3'd0, 3'd0, 16'h0001, 16'h0000, 2});
      vecs.push_back('{OP_READ, 3'd7, 3'd0, 16'h0000, 16'hFFFF, 3});
      vecs.push_back('{OP_READ, 3'd0, 3'd0, 16'h0000, 16'h0001, 3});

      // Commands go back to back: each is presented in the previous one's op_done cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].ra, vecs[i].rb,
                       vecs[i].imm, 1'b0, rdata, lat);
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
         if (vecs[i].op == OP_READ) begin
            checkOutput($sformatf("vec%0d table data", i), 32'(rdata), 32'(vecs[i].expData));
         end
      end

      // READ held in RESP by a stalled consumer.
      rspReady = 1'b0;
      reqValid = 1'b1; reqOp = OP_READ; reqRa = 3'd2; reqRb = 3'd0;
      @(posedge clk); #1;
      reqValid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("stall%0d rsp_valid", i), 32'(rspValid), 32'd1);
         checkOutput($sformatf("stall%0d rsp_data", i), 32'(rspData), 32'(model[2]));
         checkOutput($sformatf("stall%0d req_ready", i), 32'(reqReady), 32'd0);
         @(posedge clk); #1;
      end
      rspReady = 1'b1;
      checkOutput("stall release rsp_valid", 32'(rspValid), 32'd1);
      @(posedge clk); #1;
      checkOutput("stall cleared rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("stall cleared req_ready", 32'(reqReady), 32'd1);
      checkOutput("stall no op_done", 32'(opDone), 32'd0);

      // Reset asserted while a SWAP sits in its second read.
      applyStimulus("preswap1", OP_LDI, 3'd1, 3'd0, 16'hAAAA, 1'b0, rdata, lat);
      applyStimulus("preswap2", OP_LDI, 3'd2, 3'd0, 16'h5555, 1'b0, rdata, lat);
      wrLog.delete();
      reqValid = 1'b1; reqOp = OP_SWAP; reqRa = 3'd1; reqRb = 3'd2;
      @(posedge clk); #1;
      reqValid = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort readnum second", 32'(rfReadnum), 32'd2);
      resetN = 1'b0;
      #1;
      checkOutput("abort rf_write", 32'(rfWrite), 32'd0);
      checkOutput("abort req_ready", 32'(reqReady), 32'd0);
      checkOutput("abort op_done", 32'(opDone), 32'd0);
      @(posedge clk); @(posedge clk); #2;
      resetN = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort ready after release", 32'(reqReady), 32'd1);
      checkOutput("abort op_done after release", 32'(opDone), 32'd0);
      checkOutput("abort no writes", 32'(wrLog.size()), 32'd0);
      checkOutput("abort R1 kept", 32'(rf[1]), 32'h0000AAAA);
      checkOutput("abort R2 kept", 32'(rf[2]), 32'h00005555);
      applyStimulus("postabort1", OP_READ, 3'd1, 3'd0, 16'h0, 1'b0, rdata, lat);
      applyStimulus("postabort2", OP_READ, 3'd2, 3'd0, 16'h0, 1'b0, rdata, lat);

      // Random commands with a randomly stalling response consumer.
      for (int i = 0; i < 60; i++) begin
         applyStimulus($sformatf("rand%0d", i), 2'($urandom_range(0, 3)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       16'($urandom), 1'b1, rdata, lat);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Initiator-side controller for the 8-entry register file. It owns the register file's write port (writenum/write/data_in) and read port (readnum/data_out).
- Accepts one register-transfer command per handshake: load-immediate, move, swap, or read-out. Expands each command into a fixed multi-cycle sequence of register-file reads and writes.
- Sits between the instruction decode/control FSM and the register file. No register-file access happens outside this block once it is in place.

Parameters:
- DW, 16, data width; matches register width.
- AW, 3, register index width; 2**AW registers.

Ports:
- clk  input  1  rising-edge clock, shared with the register file.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  command present.
- req_ready  output  1  block can accept a command; high only in IDLE.
- req_op  input  2  00 LDI, 01 MOV, 10 SWAP, 11 READ.
- req_ra  input  AW  destination register (LDI/MOV), first register (SWAP), source register (READ).
- req_rb  input  AW  source register (MOV), second register (SWAP); ignored otherwise.
- req_imm  input  DW  immediate for LDI; ignored otherwise.
- rsp_valid  output  1  READ result valid.
- rsp_data  output  DW  READ result.
- rsp_ready  input  1  consumer accepts the result.
- op_done  output  1  one-cycle pulse on completion of LDI/MOV/SWAP.
- rf_readnum  output  AW  register file read select.
- rf_data_out  input  DW  register file read data; combinational from rf_readnum.
- rf_writenum  output  AW  register file write select.
- rf_write  output  1  register file write enable; the register file writes on the rising edge while it is high.
- rf_data_in  output  DW  register file write data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; tmp_a, tmp_b and the latched command are cleared.
  - All outputs go to 0: req_ready=0 during reset, then 1 in IDLE after reset release.
  - rf_write drops immediately.
- Reset mid-command:
  - The command is aborted with no further writes.
  - Writes already clocked into the register file stay.
  - No op_done or rsp_valid is produced.
- Accept: when req_valid & req_ready are both high at a rising edge, op/ra/rb/imm are latched. Inputs are don't-care afterwards.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, RESP.
- rf_write is asserted only in WR_A and WR_B, exactly one cycle each. In all other states it is 0, and rf_writenum/rf_data_in are 0.
- rf_readnum:
  - RD_A: the latched source (rb for MOV, ra for SWAP/READ).
  - RD_B: rb.
  - Otherwise: 0.
- Data capture: at the end of RD_A, rf_data_out is captured into tmp_a; at the end of RD_B into tmp_b.
- LDI:
  - IDLE -> WR_A (writenum=ra, data_in=imm) -> IDLE.
  - op_done is high in the first IDLE cycle after WR_A.
  - 2 cycles from accept edge to req_ready.
- MOV:
  - IDLE -> RD_A (read rb) -> WR_A (writenum=ra, data_in=tmp_a) -> IDLE.
  - op_done is high in the first IDLE cycle after WR_A.
- SWAP:
  - IDLE -> RD_A (read ra) -> RD_B (read rb) -> WR_A (writenum=ra, data_in=tmp_b) -> WR_B (writenum=rb, data_in=tmp_a) -> IDLE.
  - op_done is high in the first IDLE cycle after WR_B.
  - Both reads complete before either write, so the swap is atomic with respect to this block.
- READ:
  - IDLE -> RD_A (read ra) -> RESP.
  - In RESP: rsp_valid=1 and rsp_data=tmp_a, held stable until rsp_ready is sampled high.
  - Then -> IDLE; rsp_valid drops in that IDLE cycle.
  - If rsp_ready is already high on the first RESP cycle, RESP lasts exactly one cycle.
  - No op_done for READ.
- op_done is registered: it is high for exactly one cycle, concurrent with req_ready=1. A new command may be accepted in that same cycle.
- ra==rb:
  - SWAP runs the full sequence; the register value is unchanged.
  - MOV rewrites the register with its own value.
- No arithmetic. Data passes through unmodified at DW bits.
- One command in flight at a time; req_ready=0 in every non-IDLE state.

Test Plan:
- Reset, then LDI ra=3 imm=16'h00A5 -> rf_write high exactly one cycle with writenum=3, data_in=00A5. op_done pulses next cycle. R3 reads 00A5 via a subsequent READ.
- LDI R1=1234, LDI R2=BEEF, then SWAP ra=1 rb=2 -> readnum sequence 1,2. Writes (1,BEEF) then (2,1234) on consecutive cycles. Subsequent READs return BEEF and 1234.
- MOV ra=5 rb=1 after R1=1234 -> one read of 1, one write (5,1234), op_done. R1 is unchanged (READ returns 1234).
- READ ra=2 with rsp_ready held low 4 cycles -> rsp_valid stays high with rsp_data stable at value of R2. It clears the cycle after rsp_ready=1. req_ready stays 0 throughout.
- Back-to-back: assert req_valid with the next LDI during the op_done cycle -> accepted that edge. No idle gap, no dropped or duplicated write.
- Assert reset_n low during RD_B of a SWAP -> rf_write stays 0, no op_done. Both registers keep their pre-swap values. req_ready=1 after release.
